// File: rtl/pe_ctx_sequencer_pkg.sv
// Shared types and sizing for the per-PE context sequencer.
package pe_ctx_sequencer_pkg;

    localparam int unsigned PE_INST_W    = 48;
    localparam int unsigned PE_CTX_DEPTH = 16;
    localparam int unsigned PE_ITER_W    = 16;
    localparam int unsigned PERF_W       = 32;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context store: DEPTH x INST_W registers, one sync write port, one async read port.
module pe_ctx_mem
    import pe_ctx_sequencer_pkg::*;
#(
    parameter int unsigned INST_W = PE_INST_W,
    parameter int unsigned DEPTH  = PE_CTX_DEPTH,
    parameter int unsigned ADDR_W = $clog2(PE_CTX_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data_c
);

    logic [INST_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Per-PE configuration sequencer: replays ctx[0..len-1] iter times onto the PE inst input.
// Optional feature macro: PE_SEQ_PERF_EN adds perf_cycles / perf_stalls counters.
module pe_ctx_sequencer
    import pe_ctx_sequencer_pkg::*;
#(
    parameter int unsigned INST_W = PE_INST_W,
    parameter int unsigned DEPTH  = PE_CTX_DEPTH,
    parameter int unsigned ADDR_W = $clog2(PE_CTX_DEPTH),
    parameter int unsigned ITER_W = PE_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [INST_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic [ADDR_W:0]   ctx_len,
    input  logic [ITER_W-1:0] iter_num,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              busy,
    output logic              done
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls
`endif
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   len_q;
    logic [ITER_W-1:0] iter_q;

    logic [ADDR_W:0]   len_clamp_c;
    logic              last_ctx_c;
    logic              start_ok_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [INST_W-1:0] rd_data_c;

    // Launch qualification, clamping and next-pc read address.
    always_comb begin
        len_clamp_c = (ctx_len > LEN_MAX) ? LEN_MAX : ctx_len;
        last_ctx_c  = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
        start_ok_c  = (state_q == SEQ_IDLE) && start && !abort;
        mem_we_c    = (state_q == SEQ_IDLE) && cfg_we && !abort;
        rd_addr_c   = ADDR_W'(0);
        if (state_q == SEQ_RUN && !last_ctx_c) begin
            rd_addr_c = pc_q + ADDR_W'(1);
        end
    end

    pe_ctx_mem #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we_c),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // Sequencer FSM with pc/iter counters and registered PE instruction.
    always_ff @(posedge clk) begin
        if (rst || (abort && state_q != SEQ_IDLE)) begin
            state_q    <= SEQ_IDLE;
            pc_q       <= '0;
            iter_q     <= '0;
            len_q      <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    done <= 1'b0;
                    if (start_ok_c) begin
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        pc_q      <= '0;
                        if (len_clamp_c != '0 && iter_num != '0) begin
                            state_q    <= SEQ_RUN;
                            len_q      <= len_clamp_c;
                            iter_q     <= iter_num;
                            inst       <= rd_data_c;
                            inst_valid <= 1'b1;
                        end else begin
                            state_q <= SEQ_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (!stall) begin
                        if (last_ctx_c) begin
                            pc_q <= '0;
                            if (iter_q == ITER_W'(1)) begin
                                iter_q     <= '0;
                                state_q    <= SEQ_DONE;
                                inst       <= '0;
                                inst_valid <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                iter_q <= iter_q - ITER_W'(1);
                                inst   <= rd_data_c;
                            end
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                            inst <= rd_data_c;
                        end
                    end
                end
                SEQ_DONE: begin
                    state_q   <= SEQ_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state_q    <= SEQ_IDLE;
                    inst       <= '0;
                    inst_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    cfg_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PE_SEQ_PERF_EN
    // Saturating RUN-cycle and stall-cycle counters, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_ok_c) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state_q == SEQ_RUN) begin
            perf_cycles <= sat_inc(perf_cycles);
            if (stall) begin
                perf_stalls <= sat_inc(perf_stalls);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Self-checking bench for pe_ctx_sequencer: directed scenarios plus randomized runs against a queue model.
module tb_pe_ctx_sequencer;
    import pe_ctx_sequencer_pkg::*;

    localparam int unsigned INST_W = 48;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned ITER_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [INST_W-1:0] cfg_data = '0;
    logic              cfg_ready;
    logic [ADDR_W:0]   ctx_len = '0;
    logic [ITER_W-1:0] iter_num = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              stall = 1'b0;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              busy;
    logic              done;
`ifdef PE_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stalls;
`endif

    logic [INST_W-1:0] ctx_m [DEPTH];
    int total  = 0;
    int passed = 0;
    int fails  = 0;

    pe_ctx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .ctx_len    (ctx_len),
        .iter_num   (iter_num),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .inst       (inst),
        .inst_valid (inst_valid),
        .busy       (busy),
        .done       (done)
`ifdef PE_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_ctx(input int slot, input logic [INST_W-1:0] data);
        check("cfg_ready_idle", 64'(cfg_ready), 64'(1));
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(slot);
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
        ctx_m[slot] = data;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_inst"},  64'(inst), 64'(0));
        check({tag, "_valid"}, 64'(inst_valid), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_ready"}, 64'(cfg_ready), 64'(1));
    endtask

    // mode: 0 no stall, 1 random stall, 2 two-cycle stall on word 1,
    //       3 no stall with writes and start requests hammered during the run
    task automatic run_check(input int len_in, input int it, input int mode, input string tag);
        logic [INST_W-1:0] q [$];
        int len;
        int idx;
        int held;
        int nst;
        bit st;
        len = (len_in > int'(DEPTH)) ? int'(DEPTH) : len_in;
        for (int k = 0; k < it; k++)
            for (int i = 0; i < len; i++)
                q.push_back(ctx_m[i]);
        ctx_len  = (ADDR_W+1)'(len_in);
        iter_num = ITER_W'(it);
        start    = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; held = 0; nst = 0;
        while (idx < q.size()) begin
            check({tag, "_inst"},  64'(inst), 64'(q[idx]));
            check({tag, "_valid"}, 64'(inst_valid), 64'(1));
            check({tag, "_busy"},  64'(busy), 64'(1));
            check({tag, "_nodone"}, 64'(done), 64'(0));
            st = 1'b0;
            if (mode == 1) st = ($urandom_range(0, 3) == 0);
            if (mode == 2 && idx == 1 && held < 2) begin
                st = 1'b1;
                held++;
            end
            if (mode == 3) begin
                check({tag, "_ready_run"}, 64'(cfg_ready), 64'(0));
                cfg_we   = 1'b1;
                cfg_addr = '0;
                cfg_data = ~ctx_m[0];
                start    = 1'b1;
            end
            stall = st;
            tick();
            stall = 1'b0;
            if (st) nst++;
            else idx++;
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        check({tag, "_done"},       64'(done), 64'(1));
        check({tag, "_done_valid"}, 64'(inst_valid), 64'(0));
        check({tag, "_done_inst"},  64'(inst), 64'(0));
        check({tag, "_done_busy"},  64'(busy), 64'(1));
`ifdef PE_SEQ_PERF_EN
        check({tag, "_perf_cycles"}, 64'(perf_cycles), 64'(q.size() + nst));
        check({tag, "_perf_stalls"}, 64'(perf_stalls), 64'(nst));
`endif
        tick();
        check_idle({tag, "_end"});
`ifdef PE_SEQ_PERF_EN
        check({tag, "_perf_hold"}, 64'(perf_cycles), 64'(q.size() + nst));
`endif
    endtask

    initial begin
        logic [INST_W-1:0] w;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
`ifdef PE_SEQ_PERF_EN
        check("reset_perf_cycles", 64'(perf_cycles), 64'(0));
        check("reset_perf_stalls", 64'(perf_stalls), 64'(0));
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = {$urandom, $urandom};
            write_ctx(i, w);
        end

        // Basic replay: A,B,C,D twice
        write_ctx(0, 48'hAAAA_0000_0001);
        write_ctx(1, 48'hBBBB_0000_0002);
        write_ctx(2, 48'hCCCC_0000_0003);
        write_ctx(3, 48'hDDDD_0000_0004);
        run_check(4, 2, 0, "t1");

        // Two-cycle stall on B
        run_check(3, 1, 2, "t2");

        // Empty launches go straight to done
        run_check(0, 3, 0, "t3_len0");
        run_check(5, 0, 0, "t3_iter0");

        // Abort during the second word
        ctx_len = 5'd4; iter_num = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_first", 64'(inst), 64'(ctx_m[0]));
        tick();
        check("t4_second", 64'(inst), 64'(ctx_m[1]));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("t4_abort");
        tick();
        check("t4_nodone", 64'(done), 64'(0));
        // abort and start together in IDLE
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check_idle("t4_abort_start");
        tick();
        check_idle("t4_abort_start2");

        // Writes and start requests during RUN are dropped; then rerun shows old word
        run_check(2, 2, 3, "t5_hammer");
        run_check(2, 1, 0, "t5_rerun");
        run_check(17, 1, 0, "t5_clamp");

        // Synchronous reset mid-run; memory survives
        ctx_len = 5'd5; iter_num = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("t6_rst");
`ifdef PE_SEQ_PERF_EN
        check("t6_rst_perf_cycles", 64'(perf_cycles), 64'(0));
        check("t6_rst_perf_stalls", 64'(perf_stalls), 64'(0));
`endif
        run_check(5, 1, 0, "t6_post_rst");

        // Randomized runs with occasional context rewrites
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = {$urandom, $urandom};
                write_ctx(int'($urandom_range(0, DEPTH - 1)), w);
            end
            run_check(int'($urandom_range(0, 17)), int'($urandom_range(0, 4)), 1, "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
